// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch (IF) and load/store (LS).
// Define MEM_ARB_RR_EN for round-robin arbitration; by default LS has fixed priority over IF.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned INST_W = 32,
  parameter int unsigned TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [INST_W-1:0] if_inst,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_write,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [TYPE_W-1:0] ls_store_type,
  input  logic [TYPE_W-1:0] ls_load_type,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ram_en,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [TYPE_W-1:0] ram_store_type,
  output logic [TYPE_W-1:0] ram_load_type,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_ls_q, owner_ls_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TYPE_W-1:0]   st_q, st_d;
  logic [TYPE_W-1:0]   lt_q, lt_d;
  logic [INST_W-1:0]   if_inst_q, if_inst_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

  logic slot_open, pick_ls, accept_ls, accept_if;

`ifdef MEM_ARB_RR_EN
  logic last_ls_q, last_ls_d;
  // On a tie (both or neither valid) the requester not granted last gets the slot.
  assign pick_ls = (ls_req_valid & ~if_req_valid) | (~(ls_req_valid ^ if_req_valid) & ~last_ls_q);
`else
  assign pick_ls = ls_req_valid | ~if_req_valid;
`endif

  // Readies are held low while reset is asserted, even though state_q already reads StIdle.
  assign slot_open    = rst_n & ((state_q == StIdle) | (state_q == StResp));
  assign ls_req_ready = slot_open & pick_ls;
  assign if_req_ready = slot_open & ~pick_ls;
  assign accept_ls    = ls_req_ready & ls_req_valid;
  assign accept_if    = if_req_ready & if_req_valid;

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    st_d       = st_q;
    lt_d       = lt_q;
    if_inst_d  = if_inst_q;
    ls_rdata_d = ls_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_ls_d  = last_ls_q;
    if (accept_ls) begin
      last_ls_d = 1'b1;
    end else if (accept_if) begin
      last_ls_d = 1'b0;
    end
`endif
    case (state_q)
      StIdle, StResp: begin
        if (accept_ls) begin
          state_d    = StIssue;
          owner_ls_d = 1'b1;
          write_d    = ls_write;
          addr_d     = ls_addr;
          wdata_d    = ls_wdata;
          st_d       = ls_store_type;
          lt_d       = ls_load_type;
        end else if (accept_if) begin
          state_d    = StIssue;
          owner_ls_d = 1'b0;
          write_d    = 1'b0;
          addr_d     = if_addr;
          wdata_d    = '0;
          st_d       = '0;
          lt_d       = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: state_d = StCapt;
      StCapt: begin
        state_d    = StResp;
        // Non-owner data is cleared so only the granted side ever shows a value.
        if_inst_d  = owner_ls_q ? '0 :
                     (addr_q[2] ? ram_rdata[INST_W +: INST_W] : ram_rdata[INST_W-1:0]);
        ls_rdata_d = (owner_ls_q & ~write_q) ? ram_rdata : '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      st_q       <= '0;
      lt_q       <= '0;
      if_inst_q  <= '0;
      ls_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_ls_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      st_q       <= st_d;
      lt_q       <= lt_d;
      if_inst_q  <= if_inst_d;
      ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_ls_q  <= last_ls_d;
`endif
    end
  end

  // RAM side is only driven during the issue cycle.
  assign ram_en         = (state_q == StIssue);
  assign ram_write      = ram_en & write_q;
  assign ram_addr       = ram_en ? addr_q  : '0;
  assign ram_wdata      = ram_en ? wdata_q : '0;
  assign ram_store_type = ram_en ? st_q    : '0;
  assign ram_load_type  = ram_en ? lt_q    : '0;

  assign if_resp_valid  = (state_q == StResp) & ~owner_ls_q;
  assign ls_resp_valid  = (state_q == StResp) & owner_ls_q;
  assign if_inst        = if_inst_q;
  assign ls_rdata       = ls_rdata_q;

endmodule
